// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counting timer raising a one-shot or periodic IRQ.
// Optional: define TC_STATUS_EN to map STATUS (irq flag, FSM state, W1C clear) at offset 0xC.
module timer_counter #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic [31:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StCnt  = 2'd2,
      StInt  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic        en_q, en_d;
   logic [1:0]  mode_q, mode_d;
   logic        im_q, im_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        flag_q, flag_d;
   logic        irq_q;

   logic hit, wr_ctrl, wr_preset, one_shot;
   logic flag_set, flag_pulse_clr, en_hw_clr;
   logic unused_addr;

   assign unused_addr = ^Addr[1:0];

   assign hit       = WE && (Addr[31:4] == BASE_ADDR[31:4]);
   assign wr_ctrl   = hit && (Addr[3:2] == 2'b00);
   assign wr_preset = hit && (Addr[3:2] == 2'b01);
   assign one_shot  = (mode_q != 2'b01);

`ifdef TC_STATUS_EN
   logic wr_status;
   assign wr_status = hit && (Addr[3:2] == 2'b11);
`endif

   // Counter FSM
   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      flag_set       = 1'b0;
      flag_pulse_clr = 1'b0;
      en_hw_clr      = 1'b0;
      case (state_q)
         StIdle: begin
            if (en_q) state_d = StLoad;
         end
         StLoad: begin
            count_d = preset_q;
            state_d = StCnt;
         end
         StCnt: begin
            if (!en_q) begin
               state_d = StIdle;
            end else if (count_q != 32'd0) begin
               count_d = count_q - 32'd1;
            end else begin
               state_d  = StInt;
               flag_set = 1'b1;
            end
         end
         StInt: begin
            if (one_shot) begin
               en_hw_clr = 1'b1;
               state_d   = StIdle;
            end else begin
               flag_pulse_clr = 1'b1;
               state_d        = StLoad;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Register file next state; a CPU write to CTRL overrides the hardware EN clear.
   always_comb begin
      en_d     = en_q;
      mode_d   = mode_q;
      im_d     = im_q;
      preset_d = preset_q;
      if (en_hw_clr) en_d = 1'b0;
      if (wr_ctrl) begin
         en_d   = Din[0];
         mode_d = Din[2:1];
         im_d   = Din[3];
      end
      if (wr_preset) preset_d = Din;
   end

   // Interrupt flag: every clear source loses to a same-cycle set.
   always_comb begin
      flag_d = flag_q;
      if (one_shot && (wr_ctrl || wr_preset)) flag_d = 1'b0;
      if (flag_pulse_clr) flag_d = 1'b0;
`ifdef TC_STATUS_EN
      if (wr_status && Din[0]) flag_d = 1'b0;
`endif
      if (flag_set) flag_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q  <= StIdle;
         en_q     <= 1'b0;
         mode_q   <= 2'b00;
         im_q     <= 1'b0;
         preset_q <= 32'd0;
         count_q  <= 32'd0;
         flag_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         en_q     <= en_d;
         mode_q   <= mode_d;
         im_q     <= im_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         flag_q   <= flag_d;
         irq_q    <= flag_d & im_d;
      end
   end

   // IRQ comes straight from a flop so the CP0 input never sees a glitch.
   assign IRQ = irq_q;

   always_comb begin
      Dout = 32'd0;
      case (Addr[3:2])
         2'b00:   Dout = {28'd0, im_q, mode_q, en_q};
         2'b01:   Dout = preset_q;
         2'b10:   Dout = count_q;
         default: begin
`ifdef TC_STATUS_EN
            Dout = {29'd0, state_q, flag_q};
`else
            Dout = 32'd0;
`endif
         end
      endcase
   end

endmodule
